// File: rtl/piso_tx_if.sv
// Handshake and serial-side bundle of the parallel-in/serial-out transmitter.
// master = word source / serial sink, slave = the transmitter.
interface piso_tx_if #(
   parameter int WIDTH = 8
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] par_in;
   logic             serial_out;
   logic             serial_valid;
   logic             frame_start;
   logic             busy;

   modport master (
      output load_valid, par_in,
      input  load_ready, serial_out, serial_valid, frame_start, busy
   );

   modport slave (
      input  load_valid, par_in,
      output load_ready, serial_out, serial_valid, frame_start, busy
   );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: one bit per clock, frame_start on each word's
// first bit, and a one-word hold buffer so consecutive words stream without a gap.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | nothing on the line, shifter empty, waiting for a word
//   S_SHIFT | a word is on the line, r_cnt = index of the bit now shown
module piso_tx #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic     clk,
   input logic     rst_n,
   piso_tx_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_hold;
   logic             r_hold_full;
   logic             r_serial_out;
   logic             r_serial_valid;
   logic             r_frame_start;
   logic             r_busy;

   logic w_accept;
   logic w_last;

   function automatic logic first_bit(input logic [WIDTH-1:0] word);
      return MSB_FIRST ? word[WIDTH-1] : word[0];
   endfunction

   // Ready depends only on the hold register, never on load_valid.
   assign w_accept = bus.load_valid && !r_hold_full;
   assign w_last   = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_shift        <= '0;
         r_cnt          <= '0;
         r_hold         <= '0;
         r_hold_full    <= 1'b0;
         r_serial_out   <= 1'b0;
         r_serial_valid <= 1'b0;
         r_frame_start  <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_accept) begin
                  r_state        <= S_SHIFT;
                  r_shift        <= bus.par_in;
                  r_serial_out   <= first_bit(bus.par_in);
                  r_serial_valid <= 1'b1;
                  r_frame_start  <= 1'b1;
                  r_busy         <= 1'b1;
               end else begin
                  r_serial_out   <= 1'b0;
                  r_serial_valid <= 1'b0;
                  r_frame_start  <= 1'b0;
                  r_busy         <= 1'b0;
               end
            end

            S_SHIFT: begin
               if (w_last) begin
                  r_cnt <= '0;
                  // Frame boundary: held word first, then a same-cycle bypass, else go idle.
                  if (r_hold_full) begin
                     r_shift        <= r_hold;
                     r_serial_out   <= first_bit(r_hold);
                     r_serial_valid <= 1'b1;
                     r_frame_start  <= 1'b1;
                     r_hold_full    <= 1'b0;
                     r_busy         <= 1'b1;
                  end else if (w_accept) begin
                     r_shift        <= bus.par_in;
                     r_serial_out   <= first_bit(bus.par_in);
                     r_serial_valid <= 1'b1;
                     r_frame_start  <= 1'b1;
                     r_busy         <= 1'b1;
                  end else begin
                     r_state        <= S_IDLE;
                     r_serial_out   <= 1'b0;
                     r_serial_valid <= 1'b0;
                     r_frame_start  <= 1'b0;
                     r_busy         <= 1'b0;
                  end
               end else begin
                  r_cnt          <= r_cnt + CW'(1);
                  r_shift        <= MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                              : {1'b0, r_shift[WIDTH-1:1]};
                  r_serial_out   <= MSB_FIRST ? r_shift[WIDTH-2] : r_shift[1];
                  r_serial_valid <= 1'b1;
                  r_frame_start  <= 1'b0;
                  r_busy         <= 1'b1;
                  if (w_accept) begin
                     r_hold      <= bus.par_in;
                     r_hold_full <= 1'b1;
                  end
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.load_ready   = !r_hold_full;
   assign bus.serial_out   = r_serial_out;
   assign bus.serial_valid = r_serial_valid;
   assign bus.frame_start  = r_frame_start;
   assign bus.busy         = r_busy;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: MSB-first and LSB-first instances, hold/bypass streaming,
// async reset mid-word, and a random stream checked through a SIPO receiver model.
module tb_piso_tx;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   piso_tx_if #(.WIDTH(8)) ifm ();
   piso_tx_if #(.WIDTH(8)) ifl ();

   piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_n(rst_n), .bus(ifm.slave));
   piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(ifl.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // SIPO receiver model on the MSB-first line: shifts in at the LSB, aligned by frame_start.
   logic       mon_en;
   logic [7:0] rx_word;
   int         rx_bits;
   int         mon_err;
   logic [7:0] rx_q[$];

   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (ifm.serial_valid) begin
            if (ifm.frame_start) begin
               if (rx_bits != 0) mon_err++;
               rx_word = {7'b0, ifm.serial_out};
               rx_bits = 1;
            end else if (rx_bits == 0) begin
               mon_err++;
            end else begin
               rx_word = {rx_word[6:0], ifm.serial_out};
               rx_bits++;
            end
            if (rx_bits == 8) begin
               rx_q.push_back(rx_word);
               rx_bits = 0;
            end
         end else if (rx_bits != 0) begin
            mon_err++;
         end
      end
   end

   initial begin
      logic [7:0]  exp8;
      logic [15:0] exp16;
      logic [7:0]  exp_q[$];
      logic [7:0]  word;
      logic        rdy;
      int          nvalid;
      int          waited;

      total   = 0;
      bad     = 0;
      mon_en  = 1'b0;
      rx_word = '0;
      rx_bits = 0;
      mon_err = 0;
      ifm.load_valid = 1'b0;
      ifm.par_in     = '0;
      ifl.load_valid = 1'b0;
      ifl.par_in     = '0;
      rst_n = 1'b0;
      step();
      step();
      chk("rst_serial_out",   ifm.serial_out,   0);
      chk("rst_serial_valid", ifm.serial_valid, 0);
      chk("rst_frame_start",  ifm.frame_start,  0);
      chk("rst_busy",         ifm.busy,         0);
      rst_n = 1'b1;
      step();
      chk("rst_load_ready",   ifm.load_ready,   1);

      // 1: 0xA5 MSB first
      exp8 = 8'hA5;
      ifm.par_in = exp8;
      ifm.load_valid = 1'b1;
      step();
      ifm.load_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("t1_bit",   ifm.serial_out,   exp8[7-k]);
         chk("t1_valid", ifm.serial_valid, 1);
         chk("t1_fs",    ifm.frame_start,  (k == 0));
         step();
      end
      chk("t1_end_valid", ifm.serial_valid, 0);
      chk("t1_end_busy",  ifm.busy,         0);

      // 2: 0x01 LSB first
      exp8 = 8'h01;
      ifl.par_in = exp8;
      ifl.load_valid = 1'b1;
      step();
      ifl.load_valid = 1'b0;
      nvalid = 0;
      for (int k = 0; k < 12; k++) begin
         if (ifl.serial_valid) nvalid++;
         if (k < 8) chk("t2_bit", ifl.serial_out, exp8[k]);
         step();
      end
      chk("t2_nvalid", nvalid, 8);
      chk("t2_busy",   ifl.busy, 0);

      // 3: 0x3C then 0xC3 into the hold buffer
      exp16 = 16'h3CC3;
      ifm.par_in = 8'h3C;
      ifm.load_valid = 1'b1;
      step();
      ifm.par_in = 8'hC3;
      for (int i = 0; i < 16; i++) begin
         chk("t3_valid", ifm.serial_valid, 1);
         chk("t3_bit",   ifm.serial_out,   exp16[15-i]);
         chk("t3_fs",    ifm.frame_start,  (i == 0 || i == 8));
         if (i == 1) begin
            chk("t3_ready_held", ifm.load_ready, 0);
            ifm.load_valid = 1'b0;
         end
         if (i == 7) chk("t3_ready_last", ifm.load_ready, 0);
         if (i == 8) chk("t3_ready_after", ifm.load_ready, 1);
         step();
      end
      chk("t3_end_valid", ifm.serial_valid, 0);
      chk("t3_end_busy",  ifm.busy,         0);

      // 4: 0xFF then 0x00 offered only on the last-bit cycle (bypass)
      exp16 = 16'hFF00;
      ifm.par_in = 8'hFF;
      ifm.load_valid = 1'b1;
      step();
      ifm.load_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("t4_valid", ifm.serial_valid, 1);
         chk("t4_bit",   ifm.serial_out,   exp16[15-i]);
         chk("t4_fs",    ifm.frame_start,  (i == 0 || i == 8));
         if (i == 7) begin
            chk("t4_ready_last", ifm.load_ready, 1);
            ifm.par_in = 8'h00;
            ifm.load_valid = 1'b1;
         end
         if (i == 8) ifm.load_valid = 1'b0;
         step();
      end
      chk("t4_end_valid", ifm.serial_valid, 0);

      // 5: async reset after 3 bits of 0xF0 with 0x0F held
      ifm.par_in = 8'hF0;
      ifm.load_valid = 1'b1;
      step();
      ifm.par_in = 8'h0F;
      for (int i = 0; i < 3; i++) begin
         chk("t5_bit", ifm.serial_out, 1);
         if (i == 1) begin
            chk("t5_held", ifm.load_ready, 0);
            ifm.load_valid = 1'b0;
         end
         if (i < 2) step();
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", ifm.serial_valid, 0);
      chk("t5_rst_out",   ifm.serial_out,   0);
      chk("t5_rst_fs",    ifm.frame_start,  0);
      chk("t5_rst_busy",  ifm.busy,         0);
      step();
      rst_n = 1'b1;
      nvalid = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (ifm.serial_valid) nvalid++;
      end
      chk("t5_residual", nvalid, 0);
      chk("t5_ready",    ifm.load_ready, 1);
      chk("t5_busy",     ifm.busy,       0);

      // 6: random stream through the receiver model
      mon_en = 1'b1;
      for (int n = 0; n < 40; n++) begin
         word = 8'($urandom);
         ifm.par_in = word;
         ifm.load_valid = 1'b1;
         waited = 0;
         do begin
            rdy = ifm.load_ready;
            step();
            waited++;
         end while (!rdy && waited < 100);
         if (!rdy) chk("t6_accept_timeout", 0, 1);
         else exp_q.push_back(word);
         ifm.load_valid = 1'b0;
         ifm.par_in = 8'($urandom);
         for (int g = $urandom_range(0, 12); g > 0; g--) step();
      end
      for (int k = 0; k < 30; k++) step();
      mon_en = 1'b0;
      chk("t6_count", rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         chk("t6_word", rx_q[i], exp_q[i]);
      chk("t6_gapless", mon_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
